// File: rtl/pipe_sched_pkg.sv
// Shared definitions for the pipeline scheduler: stage indices, stall/flush patterns, FSM states.
package pipe_sched_pkg;

   localparam int STALL_BUS_W = 6;

   typedef logic [STALL_BUS_W-1:0] stall_bus_t;

   localparam int STG_PC  = 0;
   localparam int STG_IF  = 1;
   localparam int STG_ID  = 2;
   localparam int STG_EX  = 3;
   localparam int STG_MEM = 4;
   localparam int STG_WB  = 5;

   // A stalling stage also holds every younger stage in front of it.
   localparam stall_bus_t STALL_NONE = 6'b000000;
   localparam stall_bus_t STALL_MEM  = 6'b011111;
   localparam stall_bus_t STALL_EX   = 6'b001111;
   localparam stall_bus_t STALL_ID   = 6'b000111;

   // A trap kills IF/ID/EX (all younger than MEM); a branch kills IF/ID.
   localparam stall_bus_t FLUSH_NONE = 6'b000000;
   localparam stall_bus_t FLUSH_TRAP = 6'b001110;
   localparam stall_bus_t FLUSH_BR   = 6'b000110;

   typedef enum logic {
      RUN   = 1'b0,
      REDIR = 1'b1
   } sched_state_t;

endpackage

// File: rtl/pipe_sched_mem_wait_timer.sv
// Counts consecutive MEM bus-wait cycles and pulses a timeout once per stall episode.
module pipe_sched_mem_wait_timer
   import pipe_sched_pkg::*;
#(
   parameter int TIMEOUT = 255,
   parameter int CNT_W   = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic stallreq_mem,
   output logic mem_timeout
);

   logic [CNT_W-1:0] cnt;
   logic             to_done;

   // Episode counter: restarts whenever the bus wait ends, fires once, then stays quiet.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt         <= '0;
         to_done     <= 1'b0;
         mem_timeout <= 1'b0;
      end else if (!stallreq_mem) begin
         cnt         <= '0;
         to_done     <= 1'b0;
         mem_timeout <= 1'b0;
      end else if (to_done) begin
         mem_timeout <= 1'b0;
      end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
         cnt         <= '0;
         to_done     <= 1'b1;
         mem_timeout <= 1'b1;
      end else begin
         cnt         <= cnt + CNT_W'(1);
         mem_timeout <= 1'b0;
      end
   end

endmodule

// File: rtl/pipe_sched.sv
// Pipeline scheduler: merges stall requests, accepts branch/trap redirects,
// drives per-stage flush masks and a registered one-cycle PC redirect.
module pipe_sched
   import pipe_sched_pkg::*;
#(
   parameter int STALL_W = 6,
   parameter int PC_W    = 32,
   parameter int TIMEOUT = 255,
   parameter int CNT_W   = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               stallreq_id,
   input  logic               stallreq_ex,
   input  logic               stallreq_mem,
   input  logic               br_taken_ex,
   input  logic [PC_W-1:0]    br_target_ex,
   input  logic               trap_mem,
   input  logic [PC_W-1:0]    trap_vec,
   output logic [STALL_W-1:0] stall,
   output logic [STALL_W-1:0] flush,
   output logic               redirect_valid,
   output logic [PC_W-1:0]    redirect_pc,
   output logic               mem_timeout
);

   sched_state_t    state, state_nxt;
   logic [PC_W-1:0] pc_q, pc_nxt;
   stall_bus_t      stall_c, flush_c;
   logic            redir_c;
   logic            trap_acc, br_acc;

   // State and latched redirect target.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= RUN;
         pc_q  <= '0;
      end else begin
         state <= state_nxt;
         pc_q  <= pc_nxt;
      end
   end

   // Stall priority, event acceptance, flush masks and next state.
   always_comb begin
      stall_c   = STALL_NONE;
      flush_c   = FLUSH_NONE;
      redir_c   = 1'b0;
      state_nxt = RUN;
      pc_nxt    = pc_q;

      if (stallreq_mem)     stall_c = STALL_MEM;
      else if (stallreq_ex) stall_c = STALL_EX;
      else if (stallreq_id) stall_c = STALL_ID;

      // The trapping instruction in MEM is older than a branch in EX, so it wins.
      trap_acc = trap_mem & ~stallreq_mem;
      br_acc   = br_taken_ex & ~stallreq_mem & ~stallreq_ex & ~trap_mem;

      case (state)
         RUN: begin
            if (trap_acc) begin
               flush_c   = FLUSH_TRAP;
               pc_nxt    = trap_vec;
               state_nxt = REDIR;
            end else if (br_acc) begin
               flush_c   = FLUSH_BR;
               pc_nxt    = br_target_ex;
               state_nxt = REDIR;
            end
         end
         REDIR: begin
            // PC must load the redirect even if a stall is asserted; the fetch
            // already in flight is from the wrong path. EX holds a bubble, so
            // any branch request seen now is stale.
            redir_c          = 1'b1;
            stall_c[STG_PC]  = 1'b0;
            flush_c[STG_IF]  = 1'b1;
            if (trap_acc) begin
               flush_c   = flush_c | FLUSH_TRAP;
               pc_nxt    = trap_vec;
               state_nxt = REDIR;
            end
         end
         default: state_nxt = RUN;
      endcase
   end

   assign stall          = rst_n ? STALL_W'(stall_c) : '0;
   assign flush          = rst_n ? STALL_W'(flush_c) : '0;
   assign redirect_valid = rst_n & redir_c;
   assign redirect_pc    = rst_n ? pc_q : '0;

   pipe_sched_mem_wait_timer #(
      .TIMEOUT (TIMEOUT),
      .CNT_W   (CNT_W)
   ) u_timer (
      .clk          (clk),
      .rst_n        (rst_n),
      .stallreq_mem (stallreq_mem),
      .mem_timeout  (mem_timeout)
   );

endmodule

// File: tb/tb_pipe_sched.sv
// Directed bench for pipe_sched: a vector table for the stall/flush/redirect
// sequencing plus hand-written timeout and reset sequences.
module tb_pipe_sched;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stallreq_id, stallreq_ex, stallreq_mem;
   logic        br_taken_ex, trap_mem;
   logic [31:0] br_target_ex, trap_vec;
   logic [5:0]  stall, flush;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        mem_timeout;

   int n_cmp  = 0;
   int n_fail = 0;

   pipe_sched #(
      .STALL_W (6),
      .PC_W    (32),
      .TIMEOUT (4),
      .CNT_W   (8)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .stallreq_id    (stallreq_id),
      .stallreq_ex    (stallreq_ex),
      .stallreq_mem   (stallreq_mem),
      .br_taken_ex    (br_taken_ex),
      .br_target_ex   (br_target_ex),
      .trap_mem       (trap_mem),
      .trap_vec       (trap_vec),
      .stall          (stall),
      .flush          (flush),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .mem_timeout    (mem_timeout)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        id, ex, mem, br, trap;
      logic [31:0] tgt, vec;
      logic [5:0]  e_stall, e_flush;
      logic        e_rv;
      logic [31:0] e_rpc;
   } vec_t;

   vec_t tv[24];

   function automatic vec_t mk(logic id, logic ex, logic mem, logic br, logic trap,
                               logic [31:0] tgt, logic [31:0] vec,
                               logic [5:0] e_stall, logic [5:0] e_flush,
                               logic e_rv, logic [31:0] e_rpc);
      vec_t v;
      v.id = id; v.ex = ex; v.mem = mem; v.br = br; v.trap = trap;
      v.tgt = tgt; v.vec = vec;
      v.e_stall = e_stall; v.e_flush = e_flush; v.e_rv = e_rv; v.e_rpc = e_rpc;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      stallreq_id = 0; stallreq_ex = 0; stallreq_mem = 0;
      br_taken_ex = 0; trap_mem = 0;
      br_target_ex = 32'h0; trap_vec = 32'h0;
   endtask

   initial begin
      //        id ex mem br tr  target        vec           stall      flush      rv rpc
      tv[0]  = mk(0, 0, 0, 0, 0, 32'h0,        32'h0,        6'b000000, 6'b000000, 0, 32'h0);
      tv[1]  = mk(1, 0, 0, 0, 0, 32'h0,        32'h0,        6'b000111, 6'b000000, 0, 32'h0);
      tv[2]  = mk(1, 1, 0, 0, 0, 32'h0,        32'h0,        6'b001111, 6'b000000, 0, 32'h0);
      tv[3]  = mk(1, 1, 1, 0, 0, 32'h0,        32'h0,        6'b011111, 6'b000000, 0, 32'h0);
      tv[4]  = mk(0, 0, 0, 0, 0, 32'h0,        32'h0,        6'b000000, 6'b000000, 0, 32'h0);
      tv[5]  = mk(0, 0, 0, 1, 0, 32'h100,      32'h0,        6'b000000, 6'b000110, 0, 32'h0);
      tv[6]  = mk(0, 0, 0, 0, 0, 32'h0,        32'h0,        6'b000000, 6'b000010, 1, 32'h100);
      tv[7]  = mk(0, 0, 0, 0, 0, 32'h0,        32'h0,        6'b000000, 6'b000000, 0, 32'h100);
      tv[8]  = mk(0, 1, 0, 1, 0, 32'h140,      32'h0,        6'b001111, 6'b000000, 0, 32'h100);
      tv[9]  = mk(0, 1, 0, 1, 0, 32'h140,      32'h0,        6'b001111, 6'b000000, 0, 32'h100);
      tv[10] = mk(0, 1, 0, 1, 0, 32'h140,      32'h0,        6'b001111, 6'b000000, 0, 32'h100);
      tv[11] = mk(0, 0, 0, 1, 0, 32'h140,      32'h0,        6'b000000, 6'b000110, 0, 32'h100);
      tv[12] = mk(0, 0, 0, 0, 0, 32'h0,        32'h0,        6'b000000, 6'b000010, 1, 32'h140);
      tv[13] = mk(0, 0, 0, 0, 0, 32'h0,        32'h0,        6'b000000, 6'b000000, 0, 32'h140);
      tv[14] = mk(0, 0, 0, 1, 1, 32'h100,      32'h80,       6'b000000, 6'b001110, 0, 32'h140);
      tv[15] = mk(0, 0, 0, 0, 1, 32'h0,        32'hC0,       6'b000000, 6'b001110, 1, 32'h80);
      tv[16] = mk(0, 0, 0, 1, 0, 32'h300,      32'h0,        6'b000000, 6'b000010, 1, 32'hC0);
      tv[17] = mk(0, 0, 0, 0, 0, 32'h0,        32'h0,        6'b000000, 6'b000000, 0, 32'hC0);
      tv[18] = mk(0, 0, 1, 0, 1, 32'h0,        32'h90,       6'b011111, 6'b000000, 0, 32'hC0);
      tv[19] = mk(0, 0, 0, 0, 1, 32'h0,        32'h90,       6'b000000, 6'b001110, 0, 32'hC0);
      tv[20] = mk(1, 0, 0, 0, 0, 32'h0,        32'h0,        6'b000110, 6'b000010, 1, 32'h90);
      tv[21] = mk(1, 0, 0, 1, 0, 32'h1A0,      32'h0,        6'b000111, 6'b000110, 0, 32'h90);
      tv[22] = mk(0, 0, 0, 0, 0, 32'h0,        32'h0,        6'b000000, 6'b000010, 1, 32'h1A0);
      tv[23] = mk(0, 0, 0, 0, 0, 32'h0,        32'h0,        6'b000000, 6'b000000, 0, 32'h1A0);

      // Reset state; a pending stall request must not leak through while in reset.
      idle_inputs();
      stallreq_id = 1;
      rst_n = 0;
      #1;
      chk("reset stall", 32'(stall), 32'h0);
      chk("reset flush", 32'(flush), 32'h0);
      chk("reset redirect_valid", 32'(redirect_valid), 32'h0);
      chk("reset redirect_pc", redirect_pc, 32'h0);
      chk("reset mem_timeout", 32'(mem_timeout), 32'h0);
      @(negedge clk);
      stallreq_id = 0;
      @(negedge clk);
      rst_n = 1;

      // Table: drive each vector at the falling edge and check before the next rising edge.
      foreach (tv[i]) begin
         @(negedge clk);
         stallreq_id  = tv[i].id;
         stallreq_ex  = tv[i].ex;
         stallreq_mem = tv[i].mem;
         br_taken_ex  = tv[i].br;
         trap_mem     = tv[i].trap;
         br_target_ex = tv[i].tgt;
         trap_vec     = tv[i].vec;
         #1;
         chk($sformatf("v%0d stall", i), 32'(stall), 32'(tv[i].e_stall));
         chk($sformatf("v%0d flush", i), 32'(flush), 32'(tv[i].e_flush));
         chk($sformatf("v%0d redirect_valid", i), 32'(redirect_valid), 32'(tv[i].e_rv));
         chk($sformatf("v%0d redirect_pc", i), redirect_pc, tv[i].e_rpc);
         chk($sformatf("v%0d mem_timeout", i), 32'(mem_timeout), 32'h0);
      end

      // Timeout: 10-cycle MEM wait gives one pulse in the 5th stalled cycle only.
      @(negedge clk);
      idle_inputs();
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         stallreq_mem = 1;
         #1;
         chk($sformatf("to1 k%0d mem_timeout", k), 32'(mem_timeout), 32'(k == 5));
         chk($sformatf("to1 k%0d stall", k), 32'(stall), 32'h1F);
      end
      @(negedge clk);
      stallreq_mem = 0;
      #1;
      chk("to1 release mem_timeout", 32'(mem_timeout), 32'h0);
      chk("to1 release stall", 32'(stall), 32'h0);
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         stallreq_mem = 1;
         #1;
         chk($sformatf("to2 k%0d mem_timeout", k), 32'(mem_timeout), 32'(k == 5));
      end
      @(negedge clk);
      stallreq_mem = 0;

      // Reset while a branch redirect is pending: redirect is dropped.
      @(negedge clk);
      br_taken_ex = 1;
      br_target_ex = 32'h2C0;
      #1;
      chk("rst1 accept flush", 32'(flush), 32'h06);
      @(negedge clk);
      br_taken_ex = 0;
      stallreq_id = 1;
      #1;
      chk("rst1 redirect_valid", 32'(redirect_valid), 32'h1);
      chk("rst1 redirect_pc", redirect_pc, 32'h2C0);
      #2;
      rst_n = 0;
      #1;
      chk("rst1 async redirect_valid", 32'(redirect_valid), 32'h0);
      chk("rst1 async redirect_pc", redirect_pc, 32'h0);
      chk("rst1 async stall", 32'(stall), 32'h0);
      chk("rst1 async flush", 32'(flush), 32'h0);
      @(negedge clk);
      stallreq_id = 0;
      @(negedge clk);
      rst_n = 1;
      #1;
      chk("rst1 post redirect_valid", 32'(redirect_valid), 32'h0);
      chk("rst1 post redirect_pc", redirect_pc, 32'h0);
      chk("rst1 post flush", 32'(flush), 32'h0);
      @(negedge clk);
      #1;
      chk("rst1 post2 redirect_valid", 32'(redirect_valid), 32'h0);

      // Reset with the wait counter one cycle from firing: count restarts from zero.
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         stallreq_mem = 1;
      end
      @(negedge clk);
      #2;
      rst_n = 0;
      #1;
      chk("rst2 async mem_timeout", 32'(mem_timeout), 32'h0);
      @(negedge clk);
      rst_n = 1;
      #1;
      chk("rst2 k1 mem_timeout", 32'(mem_timeout), 32'h0);
      for (int k = 2; k <= 6; k++) begin
         @(negedge clk);
         #1;
         chk($sformatf("rst2 k%0d mem_timeout", k), 32'(mem_timeout), 32'(k == 5));
      end
      @(negedge clk);
      idle_inputs();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
